// File: rtl/cpu_cu.sv
// cpu_cu: control unit for a 16-bit multicycle CPU.
// Sequences FETCH/DECODE/execute, decodes the instruction register and
// drives the execution-unit strobes, selects and register-file addresses.
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   IR[15:0]              - instruction register contents
//   N, Z, C               - live ALU status flags
//   we, IR_ld, PC_ld, PC_inc, mw_en - strobes (combinational from state/IR)
//   PC_sel, s_sel, ad_sel - datapath selects
//   W_Adr, R_Adr, S_Adr   - register-file addresses from IR fields
//   ALU_OP[3:0]           - ALU operation code
//   halted, illegal       - stop indicators
//   state[3:0]            - current state code
module cpu_cu #(
  parameter logic [3:0] ALU_PASS_S = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        C,
  output logic        we,
  output logic        IR_ld,
  output logic        PC_ld,
  output logic        PC_inc,
  output logic        PC_sel,
  output logic        s_sel,
  output logic        ad_sel,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic [3:0]  ALU_OP,
  output logic        mw_en,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_ALU     = 4'd3,
    ST_LOAD    = 4'd4,
    ST_STORE   = 4'd5,
    ST_BRANCH  = 4'd6,
    ST_JR      = 4'd7,
    ST_HALT    = 4'd8,
    ST_ILLEGAL = 4'd9
  } state_e;

  state_e     r_state;
  state_e     w_next_state;
  logic [2:0] r_flags;       // {N, Z, C} captured at end of ALU cycle
  logic       w_take_branch;
  logic       w_unused;

  wire w_class = IR[15];
  wire [3:0] w_subop = IR[14:11];
  wire [2:0] w_cond  = IR[10:8];

  // IR[1:0] carry no control information.
  assign w_unused = ^IR[1:0];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RESET;
    else       r_state <= w_next_state;
  end

  // Flag register: branches see the flags of the last ALU instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_flags <= 3'b000;
    else if (r_state == ST_ALU) r_flags <= {N, Z, C};
  end

  // Branch condition evaluated against the stored flags.
  always_comb begin
    w_take_branch = 1'b0;
    case (w_cond)
      3'b000: w_take_branch = 1'b1;
      3'b001: w_take_branch = r_flags[1];
      3'b010: w_take_branch = ~r_flags[1];
      3'b011: w_take_branch = r_flags[2];
      3'b100: w_take_branch = ~r_flags[2];
      3'b101: w_take_branch = r_flags[0];
      3'b110: w_take_branch = ~r_flags[0];
      default: w_take_branch = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RESET:  w_next_state = ST_FETCH;
      ST_FETCH:  w_next_state = ST_DECODE;
      ST_DECODE: begin
        if (!w_class) begin
          w_next_state = ST_ALU;
        end else begin
          case (w_subop)
            4'b0000: w_next_state = ST_LOAD;
            4'b0001: w_next_state = ST_STORE;
            4'b0010: w_next_state = ST_BRANCH;
            4'b0011: w_next_state = ST_JR;
            4'b0100: w_next_state = ST_HALT;
            default: w_next_state = ST_ILLEGAL;
          endcase
        end
      end
      ST_ALU, ST_LOAD, ST_STORE, ST_BRANCH, ST_JR: w_next_state = ST_FETCH;
      ST_HALT:    w_next_state = ST_HALT;
      ST_ILLEGAL: w_next_state = ST_ILLEGAL;
      default:    w_next_state = ST_ILLEGAL;
    endcase
  end

  // Output logic: strobes are combinational so reset removes them at once.
  always_comb begin
    we      = 1'b0;
    IR_ld   = 1'b0;
    PC_ld   = 1'b0;
    PC_inc  = 1'b0;
    PC_sel  = 1'b0;
    s_sel   = 1'b0;
    ad_sel  = 1'b0;
    mw_en   = 1'b0;
    ALU_OP  = ALU_PASS_S;
    halted  = 1'b0;
    illegal = 1'b0;
    W_Adr   = IR[10:8];
    R_Adr   = IR[7:5];
    S_Adr   = IR[4:2];
    state   = r_state;
    case (r_state)
      ST_FETCH: begin
        IR_ld  = 1'b1;
        PC_inc = 1'b1;
      end
      ST_ALU: begin
        ALU_OP = w_subop;
        we     = 1'b1;
      end
      ST_LOAD: begin
        ad_sel = 1'b1;
        s_sel  = 1'b1;
        we     = 1'b1;
      end
      ST_STORE: begin
        ad_sel = 1'b1;
        mw_en  = 1'b1;
      end
      ST_BRANCH: PC_ld = w_take_branch;
      ST_JR: begin
        PC_sel = 1'b1;
        PC_ld  = 1'b1;
      end
      ST_HALT:    halted  = 1'b1;
      ST_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
